// File: rtl/kgp_pkg.sv
// Shared encodings for the multi-cycle KGP RISC core: instruction fields,
// opcode/funccode constants, FSM states and ALU operations.
package kgp_pkg;

  localparam int OPC_LO = 26;
  localparam int RS_LO  = 21;
  localparam int RT_LO  = 16;
  localparam int RD_LO  = 11;
  localparam int FN_LO  = 0;
  localparam int IMM_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_LW    = 6'd2;
  localparam logic [5:0] OP_SW    = 6'd3;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_XOR = 6'd3;
  localparam logic [5:0] FN_SLL = 6'd4;
  localparam logic [5:0] FN_SRA = 6'd5;
  localparam logic [5:0] FN_MUL = 6'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRA = 3'd5
  } alu_op_t;

  function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn,
                                    input logic mul_en);
    logic ok;
    ok = 1'b0;
    case (opc)
      OP_RTYPE: ok = (fn <= FN_SRA) || (mul_en && (fn == FN_MUL));
      OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/kgp_alu.sv
// Combinational ALU for the KGP RISC core: add/sub/and/xor and the two
// shifts, with the shift amount taken from the low log2(XLEN) bits of b.
module kgp_alu
  import kgp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t           op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   y_o
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt_s;
  assign shamt_s = b_i[SW-1:0];

  // operation select
  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLL: y_o = a_i << shamt_s;
      ALU_SRA: y_o = $unsigned($signed(a_i) >>> shamt_s);
      default: y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/kgp_risc_mc.sv
// Multi-cycle KGP RISC core (IDLE/DECODE/EXEC/MEM/WB) with register file and
// data memory. Define KGP_RISC_MUL_EN to add the iterative shift-add mul.
module kgp_risc_mc
  import kgp_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  output logic [XLEN-1:0]   result,
  output logic              result_valid,
  output logic              illegal
);

  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(DMEM_DEPTH);
`ifdef KGP_RISC_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  state_t          state_q, state_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] a_q, b_q, result_q, result_d;
  logic            result_valid_q, illegal_q;

  logic [5:0]      opc_s, fn_s;
  logic [RW-1:0]   rs_idx_s, rt_idx_s, rd_idx_s, wb_idx_s;
  logic [XLEN-1:0] imm_ext_s, rs_val_s, rt_val_s, alu_b_s, alu_y_s;
  logic [XLEN-1:0] exec_val_s, mem_val_s;
  logic [AW-1:0]   mem_idx_s;
  logic            legal_s, is_lw_s, is_sw_s, writes_reg_s, reg_we_s;
  logic            is_mul_s, mul_last_s;
  alu_op_t         alu_op_s;
  logic            unused_s;

  assign opc_s     = instr_q[OPC_LO +: 6];
  assign fn_s      = instr_q[FN_LO +: 6];
  assign rs_idx_s  = instr_q[RS_LO +: RW];
  assign rt_idx_s  = instr_q[RT_LO +: RW];
  assign rd_idx_s  = instr_q[RD_LO +: RW];
  assign imm_ext_s = {{(XLEN-16){instr_q[IMM_LO+15]}}, instr_q[IMM_LO +: 16]};
  assign rs_val_s  = regs_q[rs_idx_s];
  assign rt_val_s  = regs_q[rt_idx_s];
  assign unused_s  = ^instr_q;

  assign legal_s      = is_legal(opc_s, fn_s, MUL_EN);
  assign is_lw_s      = (opc_s == OP_LW);
  assign is_sw_s      = (opc_s == OP_SW);
  assign writes_reg_s = legal_s && !is_sw_s;
  assign wb_idx_s     = (opc_s == OP_RTYPE) ? rd_idx_s : rt_idx_s;
  assign alu_b_s      = (opc_s == OP_RTYPE) ? b_q : imm_ext_s;
  // the address stays valid through MEM because a_q and the immediate do not change
  assign mem_idx_s    = alu_y_s[AW-1:0];
  assign mem_val_s    = is_lw_s ? dmem[mem_idx_s] : b_q;

  // funccode to ALU operation; I-type instructions always add
  always_comb begin
    alu_op_s = ALU_ADD;
    if (opc_s == OP_RTYPE) begin
      case (fn_s)
        FN_SUB:  alu_op_s = ALU_SUB;
        FN_AND:  alu_op_s = ALU_AND;
        FN_XOR:  alu_op_s = ALU_XOR;
        FN_SLL:  alu_op_s = ALU_SLL;
        FN_SRA:  alu_op_s = ALU_SRA;
        default: alu_op_s = ALU_ADD;
      endcase
    end else begin
      alu_op_s = ALU_ADD;
    end
  end

  kgp_alu #(.XLEN(XLEN)) u_alu (
    .op_i (alu_op_s),
    .a_i  (a_q),
    .b_i  (alu_b_s),
    .y_o  (alu_y_s)
  );

`ifdef KGP_RISC_MUL_EN
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] mul_acc_q, mul_mcand_q, mul_mplier_q;
  logic [CW-1:0]   mul_cnt_q;

  assign is_mul_s   = (opc_s == OP_RTYPE) && (fn_s == FN_MUL);
  assign mul_last_s = (mul_cnt_q == CW'(XLEN-1));
  assign exec_val_s = is_mul_s ? (mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : {XLEN{1'b0}}))
                               : alu_y_s;

  // shift-add multiplier: one multiplier bit per EXEC cycle, XLEN cycles total
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
    end else if (state_q == DECODE) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= rs_val_s;
      mul_mplier_q <= rt_val_s;
      mul_cnt_q    <= '0;
    end else if ((state_q == EXEC) && is_mul_s) begin
      mul_acc_q    <= mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : {XLEN{1'b0}});
      mul_mcand_q  <= mul_mcand_q << 1;
      mul_mplier_q <= mul_mplier_q >> 1;
      mul_cnt_q    <= mul_cnt_q + CW'(1);
    end
  end
`else
  assign is_mul_s   = 1'b0;
  assign mul_last_s = 1'b1;
  assign exec_val_s = alu_y_s;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = instr_valid ? DECODE : IDLE;
      DECODE:  state_d = legal_s ? EXEC : WB;
      EXEC: begin
        if (is_lw_s || is_sw_s)        state_d = MEM;
        else if (is_mul_s && !mul_last_s) state_d = EXEC;
        else                           state_d = WB;
      end
      MEM:     state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    instr_ready = (state_q == IDLE);
    reg_we_s    = (state_q == WB) && writes_reg_s && (wb_idx_s != '0);
  end

  // value reported on entry to WB; illegal instructions report zero
  always_comb begin
    result_d = result_q;
    if (state_d == WB) begin
      case (state_q)
        DECODE:  result_d = '0;
        EXEC:    result_d = exec_val_s;
        MEM:     result_d = mem_val_s;
        default: result_d = result_q;
      endcase
    end else begin
      result_d = result_q;
    end
  end

  // instruction/operand latches and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q        <= '0;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      if ((state_q == IDLE) && instr_valid) instr_q <= instruction;
      if (state_q == DECODE) begin
        a_q <= rs_val_s;
        b_q <= rt_val_s;
      end
      result_q       <= result_d;
      result_valid_q <= (state_d == WB);
      illegal_q      <= (state_d == WB) && (state_q == DECODE) && !legal_s;
    end
  end

  // register file: cleared on reset, written only as WB retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (reg_we_s) begin
      regs_q[wb_idx_s] <= result_q;
    end
  end

  // data memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if ((state_q == MEM) && is_sw_s) dmem[mem_idx_s] <= b_q;
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_kgp_risc_mc.sv
// Directed self-checking bench for kgp_risc_mc (XLEN=32, NREG=32, DMEM_DEPTH=64).
// Build with KGP_RISC_MUL_EN to expect the iterative multiplier.
module tb_kgp_risc_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] result;
  logic        result_valid;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kgp_risc_mc #(.XLEN(32), .NREG(32), .DMEM_DEPTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .result       (result),
    .result_valid (result_valid),
    .illegal      (illegal)
  );

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  // Wait for IDLE, offer one instruction, then count cycles until result_valid.
  task automatic issue(input logic [31:0] ins, output logic [31:0] res, output int cyc,
                       output logic ill);
    int w;
    w = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    instr_valid = 1'b1;
    instruction = ins;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = 32'd0;
    cyc = 1;
    while (result_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    res = result;
    ill = illegal;
  endtask

  // Issue and compare result, completion cycle and illegal flag in one check.
  task automatic run(input string name, input logic [31:0] ins, input logic [31:0] exp_res,
                     input int exp_cyc, input logic exp_ill);
    logic [31:0] res;
    int          cyc;
    logic        ill;
    issue(ins, res, cyc, ill);
    n_checks++;
    if (res !== exp_res || cyc != exp_cyc || ill !== exp_ill) begin
      n_fail++;
      $display("FAIL %s: result=%h cycle=%0d illegal=%b, want result=%h cycle=%0d illegal=%b",
               name, res, cyc, ill, exp_res, exp_cyc, exp_ill);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'd0;
    #12;
    n_checks++;
    if (instr_ready !== 1'b1 || result !== 32'd0 || result_valid !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b result=%h valid=%b illegal=%b, want 1 0 0 0",
               instr_ready, result, result_valid, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    run("reset_regs_zero", enc_r(1, 2, 3, 0), 32'd0, 3, 1'b0);
  endtask

  task automatic test_add_chain();
    run("addi_r1_5", enc_i(1, 0, 1, 16'd5), 32'd5, 3, 1'b0);
    run("addi_r2_m3", enc_i(1, 0, 2, 16'hFFFD), 32'hFFFF_FFFD, 3, 1'b0);
    run("add_r3", enc_r(1, 2, 3, 0), 32'd2, 3, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (result_valid !== 1'b0 || result !== 32'd2) begin
      n_fail++;
      $display("FAIL pulse_hold: valid=%b result=%h, want valid=0 result=00000002",
               result_valid, result);
    end
  endtask

  task automatic test_mem();
    run("sw_r1_4", enc_i(3, 0, 1, 16'd4), 32'd5, 4, 1'b0);
    run("lw_r4_4", enc_i(2, 0, 4, 16'd4), 32'd5, 4, 1'b0);
    run("lw_alias_260", enc_i(2, 0, 5, 16'd260), 32'd5, 4, 1'b0);
    run("sw_r2_69", enc_i(3, 0, 2, 16'd69), 32'hFFFF_FFFD, 4, 1'b0);
    run("lw_word5", enc_i(2, 0, 6, 16'd5), 32'hFFFF_FFFD, 4, 1'b0);
    run("lw_word4_kept", enc_i(2, 0, 6, 16'd4), 32'd5, 4, 1'b0);
    run("lw_reg_written", enc_r(4, 0, 7, 0), 32'd5, 3, 1'b0);
  endtask

  task automatic test_alu();
    run("addi_r6_1", enc_i(1, 0, 6, 16'd1), 32'd1, 3, 1'b0);
    run("addi_r7_31", enc_i(1, 0, 7, 16'd31), 32'd31, 3, 1'b0);
    run("sll_r5", enc_r(6, 7, 5, 4), 32'h8000_0000, 3, 1'b0);
    run("addi_r8_4", enc_i(1, 0, 8, 16'd4), 32'd4, 3, 1'b0);
    run("sra_r9", enc_r(5, 8, 9, 5), 32'hF800_0000, 3, 1'b0);
    run("sub_r11", enc_r(1, 2, 11, 1), 32'd8, 3, 1'b0);
    run("and_r12", enc_r(9, 5, 12, 2), 32'h8000_0000, 3, 1'b0);
    run("xor_r13", enc_r(1, 2, 13, 3), 32'hFFFF_FFF8, 3, 1'b0);
    run("add_to_r0", enc_r(1, 1, 0, 0), 32'd10, 3, 1'b0);
    run("r0_still_zero", enc_r(0, 1, 10, 0), 32'd5, 3, 1'b0);
  endtask

  task automatic test_illegal();
    int   cyc;
    logic seen_ready;
    run("opcode63", {6'd63, 5'd0, 5'd1, 16'd7}, 32'd0, 2, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (illegal !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: illegal=%b valid=%b one cycle later, want 0 0",
               illegal, result_valid);
    end
    run("funccode7", enc_r(2, 2, 1, 7), 32'd0, 2, 1'b1);

    // hold instr_valid high with a different instruction while busy
    @(negedge clk);
    while (instr_ready !== 1'b1) @(negedge clk);
    instr_valid = 1'b1;
    instruction = {6'd63, 26'd0};
    @(posedge clk);
    #1;
    instruction = enc_i(1, 0, 1, 16'd99);
    cyc = 1;
    seen_ready = 1'b0;
    while (result_valid !== 1'b1 && cyc < 60) begin
      if (instr_ready !== 1'b0) seen_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (instr_ready !== 1'b0) seen_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = 32'd0;
    n_checks++;
    if (seen_ready !== 1'b0 || cyc != 2) begin
      n_fail++;
      $display("FAIL busy_not_ready: ready_seen=%b cycle=%0d, want 0 and 2", seen_ready, cyc);
    end
    run("regs_unchanged", enc_r(1, 0, 14, 0), 32'd5, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    while (instr_ready !== 1'b1) @(negedge clk);
    instr_valid = 1'b1;
    instruction = enc_i(2, 0, 4, 16'd5);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = 32'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1 || result !== 32'd0 || result_valid !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_mem: ready=%b result=%h valid=%b illegal=%b, want 1 0 0 0",
               instr_ready, result, result_valid, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (instr_ready !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ready=%b valid=%b, want 1 0", instr_ready, result_valid);
    end
    run("r4_not_written", enc_r(4, 0, 15, 0), 32'd0, 3, 1'b0);
    run("dmem_kept", enc_i(2, 0, 16, 16'd4), 32'd5, 4, 1'b0);
  endtask

  task automatic test_mul();
    run("addi_r20_7", enc_i(1, 0, 20, 16'd7), 32'd7, 3, 1'b0);
    run("addi_r21_m6", enc_i(1, 0, 21, 16'hFFFA), 32'hFFFF_FFFA, 3, 1'b0);
`ifdef KGP_RISC_MUL_EN
    run("mul_7_m6", enc_r(20, 21, 22, 6), 32'hFFFF_FFD6, 34, 1'b0);
    run("mul_result_written", enc_r(22, 0, 23, 0), 32'hFFFF_FFD6, 3, 1'b0);
`else
    run("mul_illegal", enc_r(20, 21, 22, 6), 32'd0, 2, 1'b1);
    run("mul_no_write", enc_r(22, 0, 23, 0), 32'd0, 3, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_add_chain();
    test_mem();
    test_alu();
    test_illegal();
    test_reset_mid();
    test_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
